// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates entries in program order, marks them done on
// writeback by tag, and retires them from the head through a ready/valid commit port.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int PHYS_W = 6,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              alloc_valid,
  input  logic              alloc_has_rd,
  input  logic [4:0]        alloc_arch_rd,
  input  logic [PHYS_W-1:0] alloc_phys_rd,
  input  logic [PHYS_W-1:0] alloc_old_phys_rd,
  input  logic [31:0]       alloc_pc,
  output logic [TAG_W-1:0]  alloc_tag,
  output logic              rob_full,
  output logic              rob_empty,
  output logic [TAG_W:0]    rob_count,

  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic              wb_exception,

  output logic              commit_valid,
  input  logic              commit_ready,
  output logic              commit_has_rd,
  output logic [4:0]        commit_arch_rd,
  output logic [PHYS_W-1:0] commit_phys_rd,
  output logic [PHYS_W-1:0] commit_old_phys_rd,
  output logic [31:0]       commit_pc,
  output logic              commit_exception,

  input  logic              flush
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W + 1)'(DEPTH);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_done;
  logic [DEPTH-1:0]  r_exc;
  logic              r_hasRd   [DEPTH];
  logic [4:0]        r_archRd  [DEPTH];
  logic [PHYS_W-1:0] r_physRd  [DEPTH];
  logic [PHYS_W-1:0] r_oldPhys [DEPTH];
  logic [31:0]       r_pc      [DEPTH];

  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [TAG_W:0]    r_count;

  logic w_full;
  logic w_commitValid;
  logic w_allocFire;
  logic w_commitFire;
  logic w_wbFire;

  assign w_full        = (r_count == FULL_COUNT);
  assign w_commitValid = r_valid[r_head] & r_done[r_head];
  assign w_allocFire   = alloc_valid & ~w_full & ~flush;
  assign w_commitFire  = w_commitValid & commit_ready & ~flush;
  // A head entry that retires this cycle must not be touched by a late writeback.
  assign w_wbFire      = wb_valid & r_valid[wb_tag] & ~flush &
                         ~(w_commitFire & (wb_tag == r_head));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_done  <= '0;
      r_exc   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_valid <= '0;
      r_done  <= '0;
      r_exc   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wbFire) begin
        r_done[wb_tag] <= 1'b1;
        r_exc[wb_tag]  <= wb_exception;
      end
      if (w_commitFire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + TAG_ONE;
      end
      if (w_allocFire) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_exc[r_tail]   <= 1'b0;
        r_tail          <= r_tail + TAG_ONE;
      end
      case ({w_allocFire, w_commitFire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload fields are only meaningful while the valid bit is set, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_allocFire) begin
      r_hasRd[r_tail]   <= alloc_has_rd;
      r_archRd[r_tail]  <= alloc_arch_rd;
      r_physRd[r_tail]  <= alloc_phys_rd;
      r_oldPhys[r_tail] <= alloc_old_phys_rd;
      r_pc[r_tail]      <= alloc_pc;
    end
  end

  assign alloc_tag          = r_tail;
  assign rob_full           = w_full;
  assign rob_empty          = (r_count == '0);
  assign rob_count          = r_count;

  assign commit_valid       = w_commitValid;
  assign commit_has_rd      = r_hasRd[r_head];
  assign commit_arch_rd     = r_archRd[r_head];
  assign commit_phys_rd     = r_physRd[r_head];
  assign commit_old_phys_rd = r_oldPhys[r_head];
  assign commit_pc          = r_pc[r_head];
  assign commit_exception   = r_exc[r_head];

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order reorder buffer (ROB) for the p6 out-of-order core. It allocates one entry per dispatched instruction and tracks writeback completion by tag. It retires entries strictly in program order through a ready/valid commit port. It is the producer of `rob_full`, which the frontend stall logic consumes, and the consumer of that logic's dispatch-increment and retire-decrement events.

## Interface
Parameters:
- `DEPTH`, default 16: number of entries; power of two, at least 2.
- `PHYS_W`, default 6: physical register tag width.
- `TAG_W`, default `$clog2(DEPTH)`: derived; never overridden.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `alloc_valid`  in  1  dispatch request (frontend increment).
- `alloc_has_rd`  in  1  instruction writes a destination register.
- `alloc_arch_rd`  in  5  architectural destination.
- `alloc_phys_rd`  in  PHYS_W  new physical destination.
- `alloc_old_phys_rd`  in  PHYS_W  previous mapping, freed on commit.
- `alloc_pc`  in  32  instruction PC.
- `alloc_tag`  out  TAG_W  index the next accepted allocation receives (tail pointer).
- `rob_full`  out  1  count == DEPTH.
- `rob_empty`  out  1  count == 0.
- `rob_count`  out  TAG_W+1  occupied entries.
- `wb_valid`  in  1  execution-complete strobe.
- `wb_tag`  in  TAG_W  entry completing.
- `wb_exception`  in  1  completing instruction faulted.
- `commit_valid`  out  1  head entry valid and done.
- `commit_ready`  in  1  retire acknowledge (frontend decrement).
- `commit_has_rd`, `commit_arch_rd`, `commit_phys_rd`, `commit_old_phys_rd`, `commit_pc`, `commit_exception`  out  —  head entry fields, same widths as alloc/wb.
- `flush`  in  1  discard all entries.

## Operation
- State: circular array of DEPTH entries. Each entry holds valid, done, exception, has_rd, arch_rd, phys_rd, old_phys_rd, and pc. Also head and tail pointers (TAG_W, natural wrap DEPTH-1 -> 0) and count (TAG_W+1).
- Allocate fires when `alloc_valid && !rob_full`:
  - writes fields at tail, sets valid=1, done=0, exception=0;
  - tail+1, count+1.
- `alloc_valid` while full is dropped silently; the frontend must stall on `rob_full`.
- A full ROB blocks allocation even if a commit fires in the same cycle.
- Writeback when `wb_valid`: if entry[`wb_tag`].valid, set done=1 and exception=`wb_exception`. Writeback to an invalid entry is ignored.
- Commit:
  - `commit_valid` = entry[head].valid && entry[head].done; the commit_* fields mirror entry[head].
  - Commit fires on `commit_valid && commit_ready`: clears entry[head].valid, head+1, count-1.
  - An exception entry retires like any other; the consumer raises `flush` afterwards.
- Alloc and commit in the same cycle: count unchanged, both pointers advance.
- Writeback targeting the head in the cycle it commits has no effect; the entry is already retiring.
- Flush is synchronous and has highest priority:
  - clears every valid bit; head=tail=count=0;
  - alloc, writeback and commit are all ignored that cycle.
- Reset (async, `reset`=0): same state as flush. Outputs `rob_empty`=1, `rob_full`=0, `rob_count`=0, `alloc_tag`=0, `commit_valid`=0. Reset mid-operation discards in-flight entries immediately.

## Timing
- All outputs derive from registers only. There are no combinational input-to-output paths.
- `rob_full`, `rob_empty`, `rob_count` and `alloc_tag` reflect allocations and commits from the following cycle.
- Minimum alloc-to-commit latency is 2 edges: alloc at edge N, writeback sampled at edge N+1, `commit_valid` high in cycle after N+1.
- At most one commit per cycle. Sustained throughput is one alloc plus one commit per cycle.
- Done state persists until commit. `commit_valid` stays asserted with stable fields until `commit_ready`.

## Test plan
- Reset, then 16 allocs with no writeback -> `rob_full`=1, `rob_count`=16; 17th alloc dropped; `alloc_tag` stays 0.
- Alloc tags 0,1,2; writeback 2 then 0 -> commit_valid only for tag 0; after commit, head=1 is not done so `commit_valid`=0 until tag 1 writes back; then 1 and 2 retire in order.
- Hold full, alloc+commit same cycle -> alloc dropped, count 16->15. In steady state with one alloc and one commit every cycle, count stays constant over 40 cycles and tail wraps past 15 -> 0.
- Writeback with `wb_exception`=1 on tag 3 -> at head, `commit_exception`=1 with tag 3's pc. Then `flush` -> `rob_empty`=1, `alloc_tag`=0, next alloc gets tag 0.
- Writeback to an unallocated tag 5 -> no state change; later alloc into 5 starts with done=0.
- Assert `reset` low mid-stream with 7 entries live -> all outputs return to reset values immediately, before the next clock edge.
